// File: rtl/jtag_pkg.sv
// Shared TAP definitions: controller state encoding, instruction codes and IR capture pattern.
package jtag_pkg;

  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PAU_DR = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PAU_IR = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_t;

  localparam int unsigned INSTR_EXTEST = 0;
  localparam int unsigned INSTR_SAMPLE = 1;
  localparam int unsigned INSTR_IDCODE = 2;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_bsr_cell.sv
// One boundary-scan cell: capture/shift flop, update flop and functional/test output mux.
module jtag_bsr_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic capture,
  input  logic shift,
  input  logic update,
  input  logic mode,
  input  logic si,
  input  logic func_in,
  output logic so,
  output logic out
);

  logic sh_q;
  logic upd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      if (capture)     sh_q <= func_in;
      else if (shift)  sh_q <= si;
      if (update)      upd_q <= sh_q;
    end
  end

  assign so  = sh_q;
  assign out = mode ? upd_q : func_in;

endmodule

// File: rtl/jtag_tap_bscan.sv
// 1149.1-style TAP with IR, BYPASS, SAMPLE/PRELOAD, EXTEST and a parametrised boundary-scan chain.
// Define JTAG_IDCODE_EN to add the 32-bit IDCODE register and make IDCODE the reset instruction.
module jtag_tap_bscan
  import jtag_pkg::*;
#(
  parameter int unsigned IR_W       = 2,
  parameter int unsigned BSR_LEN    = 36,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
  input  logic               TCLK,
  input  logic               TRST,
  input  logic               TMS,
  input  logic               TDI,
  output logic               TDO,
  output logic               TDO_EN,
  input  logic [BSR_LEN-1:0] func_in,
  output logic [BSR_LEN-1:0] bsr_out,
  output tap_state_t         tap_state,
  output logic [IR_W-1:0]    ir_q
);

  if (IR_W < 2 || !IDCODE_VAL[0]) begin : g_param_check
    $error("jtag_tap_bscan: IR_W must be >= 2 and IDCODE_VAL[0] must be 1");
  end

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_W-1:0] RESET_IR = IR_W'(INSTR_IDCODE);
`else
  localparam logic [IR_W-1:0] RESET_IR = '1;
`endif

  tap_state_t state_q, state_d;

  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) state_q <= TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = TMS ? TLR    : RTI;
      RTI:    state_d = TMS ? SEL_DR : RTI;
      SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
      PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
      EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_d = TMS ? SEL_DR : RTI;
      SEL_IR: state_d = TMS ? TLR    : CAP_IR;
      CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
      PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
      EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  logic [IR_W-1:0] ir_sh_q;

  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      ir_sh_q <= '0;
      ir_q    <= RESET_IR;
    end else begin
      case (state_q)
        TLR:     ir_q    <= RESET_IR;
        CAP_IR:  ir_sh_q <= IR_W'(IR_CAPTURE);
        SH_IR:   ir_sh_q <= {TDI, ir_sh_q[IR_W-1:1]};
        UPD_IR:  ir_q    <= ir_sh_q;
        default: ;
      endcase
    end
  end

  logic extest, sel_bsr, sel_idcode, sel_bypass;

  always_comb begin
    extest     = (ir_q == IR_W'(INSTR_EXTEST));
    sel_bsr    = extest || (ir_q == IR_W'(INSTR_SAMPLE));
`ifdef JTAG_IDCODE_EN
    sel_idcode = (ir_q == IR_W'(INSTR_IDCODE));
`else
    sel_idcode = 1'b0;
`endif
    sel_bypass = !sel_bsr && !sel_idcode;
  end

  logic bypass_q;

  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST)                                  bypass_q <= 1'b0;
    else if (sel_bypass && state_q == CAP_DR)   bypass_q <= 1'b0;
    else if (sel_bypass && state_q == SH_DR)    bypass_q <= TDI;
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] idcode_q;

  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST)                                  idcode_q <= '0;
    else if (sel_idcode && state_q == CAP_DR)   idcode_q <= IDCODE_VAL;
    else if (sel_idcode && state_q == SH_DR)    idcode_q <= {TDI, idcode_q[31:1]};
  end
`endif

  // chain[BSR_LEN] is the TDI end, chain[0] feeds TDO.
  logic [BSR_LEN:0] chain;
  logic             bsr_cap, bsr_sh, bsr_upd;

  assign chain[BSR_LEN] = TDI;
  assign bsr_cap = sel_bsr && (state_q == CAP_DR);
  assign bsr_sh  = sel_bsr && (state_q == SH_DR);
  assign bsr_upd = sel_bsr && (state_q == UPD_DR);

  for (genvar i = 0; i < BSR_LEN; i++) begin : g_cell
    jtag_bsr_cell u_cell (
      .clk     (TCLK),
      .rst_n   (TRST),
      .capture (bsr_cap),
      .shift   (bsr_sh),
      .update  (bsr_upd),
      .mode    (extest),
      .si      (chain[i+1]),
      .func_in (func_in[i]),
      .so      (chain[i]),
      .out     (bsr_out[i])
    );
  end

  always_comb begin
    TDO    = 1'b0;
    TDO_EN = 1'b0;
    if (state_q == SH_IR) begin
      TDO    = ir_sh_q[0];
      TDO_EN = 1'b1;
    end else if (state_q == SH_DR) begin
      TDO_EN = 1'b1;
      if (sel_bsr) TDO = chain[0];
`ifdef JTAG_IDCODE_EN
      else if (sel_idcode) TDO = idcode_q[0];
`endif
      else TDO = bypass_q;
    end
  end

  assign tap_state = state_q;

endmodule
